logic_unit_seq: RTL and testbench
=================================

// Module: logic_unit_seq
// PURPOSE
//   Multi-cycle, parametrised bitwise logic unit. Successor to the fixed 32-bit combinational NOR.
//   Processes WIDTH-bit operands SLICE bits per clock, LSB slice first.
//   Provides eight logic ops, a start/busy/done handshake and a zero flag.
//   Sits beside the ALU datapath when a narrow slice datapath is required for area.
// PARAMETERS
//   WIDTH  32  operand/result width; must be a multiple of SLICE
//   SLICE  8   bits processed per RUN cycle; N = WIDTH/SLICE RUN cycles per op
// PORTS
//   clk     in   1      single clock, all state changes on rising edge
//   rst_n   in   1      synchronous, active-low reset
//   start   in   1      op request; sampled only in IDLE
//   op      in   3      000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 NOT a, 111 pass a
//   a       in   WIDTH  operand A; captured on accepted start
//   b       in   WIDTH  operand B; captured on accepted start
//   busy    out  1      high in RUN and DONE
//   done    out  1      one-cycle pulse; res/zero final while high
//   res     out  WIDTH  result register
//   zero    out  1      res == 0; valid from done, held until next start
// BEHAVIOUR
//   Reset (rst_n low at edge): state=IDLE, busy=0, done=0, res=0, zero=0, slice idx=0, op regs cleared.
//     Reset is honoured mid-RUN/DONE; the op in flight is discarded with no done pulse.
//   FSM states and transitions:
//     IDLE -> RUN: when start=1. Latch a, b and op; clear res to 0; idx=0; busy=1.
//     RUN: each edge writes res[idx*SLICE +: SLICE] = op(a_slice, b_slice), then idx++.
//     RUN -> DONE: at the edge processing idx=N-1. done=1, zero=(final res==0).
//     DONE -> IDLE: next edge. done=0, busy=0. res and zero hold.
//   Latency: start edge E0, slices at E1..EN, done high after EN. Default config: 4 cycles.
//   During RUN, res shows completed low slices; not-yet-processed high slices read 0.
//   start while busy (RUN or DONE) is ignored and not queued.
//   Input changes after E0 have no effect (captured operands are used).
//   WIDTH == SLICE: N=1; RUN lasts one cycle.
//   idx width = clog2(N), minimum 1 bit. idx never exceeds N-1.
//   Elaboration-time check: WIDTH % SLICE != 0 stops elaboration.
// CONFIGURATION
//   LOGIC_UNIT_PARITY_EN defined:
//     Adds output port `parity` (1 bit) = XOR-reduce of the final res.
//     Accumulated per slice during RUN; valid with done; held until next start.
//     Reset value 0; cleared on start.
//   Not defined: the parity port and its logic are absent; all other behaviour is identical.
// TESTING (WIDTH=32, SLICE=8)
//   1. Basic NOR. a=0x9000000A, b=0x1000001E, op=011, start 1 cycle
//      -> done 4 cycles later, res=0x6FFFFFE1, zero=0.
//   2. Two ops without reset. a=0xF046003A, b=0x70C0061F:
//      op=001 -> res=0xF0C6063F; then op=000 -> res=0x7040001A; zero=0 for both.
//   3. Zero flag. a=0xFFFFFFFF, b=0, op=000 -> res=0, zero=1, done single-cycle.
//   4. start held high through RUN/DONE. Exactly one op executes per IDLE visit.
//      Operands changed at E1 do not alter the result of test 1.
//   5. rst_n low at E2 of an op -> next cycle busy=0, done=0, res=0.
//      No done pulse follows. A new op then completes normally.
//   6. [LOGIC_UNIT_PARITY_EN] a=0x9000000A, b=0x1000001E, op=010 -> res=0x80000014, parity=1.
//      Test 1 gives parity=0.

Source files
------------

// File: rtl/logic_unit_seq_if.sv
// Handshake/data bundle for logic_unit_seq.
// The parity signal exists only when LOGIC_UNIT_PARITY_EN is defined.
interface logic_unit_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             zero;
`ifdef LOGIC_UNIT_PARITY_EN
    logic             parity;
`endif

    modport master (
        output start, op, a, b,
`ifdef LOGIC_UNIT_PARITY_EN
        input  parity,
`endif
        input  busy, done, res, zero
    );

    modport slave (
        input  start, op, a, b,
`ifdef LOGIC_UNIT_PARITY_EN
        output parity,
`endif
        output busy, done, res, zero
    );
endinterface

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: WIDTH-bit operands processed SLICE bits
// per clock, LSB slice first, with start/busy/done handshake and zero flag.
// Optional feature macro: LOGIC_UNIT_PARITY_EN adds a parity output
// (XOR-reduce of the final result, accumulated slice by slice).
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    logic_unit_seq_if.slave   bus
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    // Reject configurations where the operand does not split into whole slices.
    generate
        if (SLICE < 1) begin : g_bad_slice
            $error("logic_unit_seq: SLICE must be at least 1");
        end else if (WIDTH % SLICE != 0) begin : g_bad_width
            $error("logic_unit_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    idx;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             zero_q;
    logic [SLICE-1:0] a_sl, b_sl, r_sl;
    logic [WIDTH-1:0] res_nxt;
`ifdef LOGIC_UNIT_PARITY_EN
    logic             parity_q;
`endif

    function automatic logic [SLICE-1:0] slice_op(
        input logic [2:0]       o,
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y
    );
        case (o)
            3'b000:  slice_op = x & y;
            3'b001:  slice_op = x | y;
            3'b010:  slice_op = x ^ y;
            3'b011:  slice_op = ~(x | y);
            3'b100:  slice_op = ~(x & y);
            3'b101:  slice_op = ~(x ^ y);
            3'b110:  slice_op = ~x;
            default: slice_op = x;
        endcase
    endfunction

    // Current slice operands, its result, and the result word with it merged in.
    always_comb begin
        a_sl    = a_q[int'(idx)*SLICE +: SLICE];
        b_sl    = b_q[int'(idx)*SLICE +: SLICE];
        r_sl    = slice_op(op_q, a_sl, b_sl);
        res_nxt = res_q;
        res_nxt[int'(idx)*SLICE +: SLICE] = r_sl;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state: start only honoured in IDLE; RUN ends on the last slice.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (idx == LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: capture on start, one slice per RUN cycle, flags on the last slice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        res_q    <= '0;
                        idx      <= '0;
                        zero_q   <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
                        parity_q <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    res_q    <= res_nxt;
`ifdef LOGIC_UNIT_PARITY_EN
                    parity_q <= parity_q ^ (^r_sl);
`endif
                    // idx parks on the last slice so it never exceeds N-1.
                    if (idx == LAST) zero_q <= (res_nxt == '0);
                    else             idx    <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.res  = res_q;
    assign bus.zero = zero_q;
`ifdef LOGIC_UNIT_PARITY_EN
    assign bus.parity = parity_q;
`endif
endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq (WIDTH=32, SLICE=8).
module tb_logic_unit_seq;
    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int N     = WIDTH / SLICE;

    logic clk;
    logic rst_n;

    logic_unit_seq_if #(.WIDTH(WIDTH)) bus ();

    logic_unit_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             par;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   fails    = 0;
    int   done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [2:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        case (o)
            3'b000:  model = x & y;
            3'b001:  model = x | y;
            3'b010:  model = x ^ y;
            3'b011:  model = ~(x | y);
            3'b100:  model = ~(x & y);
            3'b101:  model = ~(x ^ y);
            3'b110:  model = ~x;
            default: model = x;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_res", bus.res, e.res);
                chk("sb_zero", bus.zero, e.zero);
`ifdef LOGIC_UNIT_PARITY_EN
                chk("sb_parity", bus.parity, e.par);
`endif
            end
        end
    end

    // One op: start for one cycle (or held through RUN/DONE), check partial
    // results each RUN cycle, done latency and the single-cycle done pulse.
    task automatic run_op(input logic [2:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input bit hold);
        exp_t e;
        logic [WIDTH-1:0] m;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        e.res  = model(o, x, y);
        e.zero = (e.res == '0);
        e.par  = ^e.res;
        sb.push_back(e);
        #1;
        if (!hold) bus.start = 1'b0;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            if (hold && k == 1) begin
                bus.a = $urandom;
                bus.b = $urandom;
                bus.op = 3'($urandom_range(0, 7));
            end
            if (k < N) begin
                m = (WIDTH'(1) << (SLICE * k)) - 1'b1;
                chk("partial_res", bus.res, e.res & m);
                chk("run_busy", bus.busy, 1);
                chk("run_done", bus.done, 0);
            end else begin
                chk("done_latency", bus.done, 1);
                chk("done_busy", bus.busy, 1);
            end
        end
        @(posedge clk);
        #1;
        chk("done_pulse", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("res_hold", bus.res, e.res);
        if (hold) bus.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_res", bus.res, 0);
        chk("rst_zero", bus.zero, 0);
`ifdef LOGIC_UNIT_PARITY_EN
        chk("rst_parity", bus.parity, 0);
`endif
        rst_n = 1'b1;

        // Basic NOR
        run_op(3'b011, 32'h9000000A, 32'h1000001E, 1'b0);
        chk("t1_res", bus.res, 32'h6FFFFFE1);
        chk("t1_zero", bus.zero, 0);
`ifdef LOGIC_UNIT_PARITY_EN
        chk("t1_parity", bus.parity, 0);
`endif

        // Two ops back to back without reset
        run_op(3'b001, 32'hF046003A, 32'h70C0061F, 1'b0);
        chk("t2_or_res", bus.res, 32'hF0C6063F);
        chk("t2_or_zero", bus.zero, 0);
        run_op(3'b000, 32'hF046003A, 32'h70C0061F, 1'b0);
        chk("t2_and_res", bus.res, 32'h7040001A);
        chk("t2_and_zero", bus.zero, 0);

        // Zero flag
        run_op(3'b000, 32'hFFFFFFFF, 32'h0, 1'b0);
        chk("t3_res", bus.res, 0);
        chk("t3_zero", bus.zero, 1);

        // start held through RUN/DONE, operands changed at E1
        d0 = done_cnt;
        run_op(3'b011, 32'h9000000A, 32'h1000001E, 1'b1);
        chk("t4_res", bus.res, 32'h6FFFFFE1);
        repeat (8) @(posedge clk);
        #1;
        chk("t4_one_op", done_cnt - d0, 1);
        chk("t4_idle", bus.busy, 0);

        // Reset in the middle of RUN
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.a     = 32'h12345678;
        bus.b     = 32'h0F0F0F0F;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_pre_busy", bus.busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_done", bus.done, 0);
        chk("t5_res", bus.res, 0);
        chk("t5_zero", bus.zero, 0);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_no_done", done_cnt - d0, 0);
        run_op(3'b101, 32'hA5A5_0000, 32'h5A5A_FFFF, 1'b0);
        chk("t5_after_res", bus.res, 32'h0000_0000);
        chk("t5_after_zero", bus.zero, 1);

`ifdef LOGIC_UNIT_PARITY_EN
        run_op(3'b010, 32'h9000000A, 32'h1000001E, 1'b0);
        chk("t6_res", bus.res, 32'h80000014);
        chk("t6_parity", bus.parity, 1);
`endif

        // Every op code with random operands
        for (int o = 0; o < 8; o++) begin
            run_op(3'(o), $urandom, $urandom, 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
